// File: rtl/pwl_pkg.sv
// Shared constants and types for the PWL activation unit and its request scheduler.
package pwl_pkg;

  localparam int PWL_M     = 4;
  localparam int PWL_N     = 8;
  localparam int PWL_WIDTH = PWL_M + PWL_N;
  localparam int PWL_K_W   = PWL_WIDTH;
  localparam int PWL_B_W   = PWL_WIDTH;
  localparam int MAX_REQ   = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r++;
    end
    return r;
  endfunction

  localparam int TAG_IDX_W = clog2(MAX_REQ);

  // Requester index travelling alongside its operand through the PWL.
  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } pwl_tag_t;

endpackage

// File: rtl/pwl_share_sched_if.sv
// Bus between the requester lanes, the scheduler and the shared PWL instance.
interface pwl_share_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 12
);

  // req_valid/req_ready: operand i is taken in the cycle both bits are high;
  // valid must not depend on ready. rsp_valid is a 1-cycle strobe with no backpressure.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_x;
  logic [NUM_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]         pwl_x;
  logic [WIDTH-1:0]         pwl_y;
  logic [NUM_REQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]         rsp_y;

  modport master (
    output req_valid, req_x, pwl_y,
    input  req_ready, pwl_x, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_x, pwl_y,
    output req_ready, pwl_x, rsp_valid, rsp_y
  );

endinterface

// File: rtl/pwl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from (valid, ptr) and the registered pointer.
module pwl_rr_arbiter
  import pwl_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   gnt_idx
);

  logic [PTR_W-1:0] r_ptr;
  logic             w_hit_hi;
  logic             w_hit_lo;
  logic [PTR_W-1:0] w_idx_hi;
  logic [PTR_W-1:0] w_idx_lo;
  logic             w_any;

  // Descending scan so the last hit written is the lowest index in each half.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i]) begin
        if (PTR_W'(i) >= r_ptr) begin
          w_hit_hi = 1'b1;
          w_idx_hi = PTR_W'(i);
        end else begin
          w_hit_lo = 1'b1;
          w_idx_lo = PTR_W'(i);
        end
      end
    end
  end

  always_comb begin
    w_any   = en && (w_hit_hi || w_hit_lo);
    gnt_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
    gnt     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      gnt[i] = w_any && (gnt_idx == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/pwl_share_sched.sv
// Time-shares one PWL unit among NUM_REQ requesters with RR issue and a latency-matched tag pipe.
// Optional perf counters (grant_cnt, busy_cnt, perf_clr) under PWL_SHARE_SCHED_PERF_EN.
module pwl_share_sched
  import pwl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = PWL_WIDTH,
  parameter int PWL_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  pwl_share_sched_if.slave      bus,
`ifdef PWL_SHARE_SCHED_PERF_EN
  input  logic                  perf_clr,
  output logic [NUM_REQ*16-1:0] grant_cnt,
  output logic [31:0]           busy_cnt,
`endif
  output logic                  busy
);

  localparam int PTR_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0] w_gnt;
  logic [PTR_W-1:0]   w_gnt_idx;
  logic               w_hs;
  logic [WIDTH-1:0]   w_sel_x;
  logic               w_busy;
  pwl_tag_t           w_out_tag;

  logic [WIDTH-1:0]   r_pwl_x;
  pwl_tag_t           r_tag [PWL_LAT+1];
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_y;

  pwl_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .valid   (bus.req_valid),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_hs = |w_gnt;

  always_comb begin
    w_sel_x = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_gnt[i]) w_sel_x = w_sel_x | bus.req_x[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwl_x <= '0;
      for (int s = 0; s <= PWL_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0].valid <= w_hs;
      r_tag[0].idx   <= TAG_IDX_W'(w_gnt_idx);
      for (int s = 1; s <= PWL_LAT; s++) r_tag[s] <= r_tag[s-1];
      if (w_hs) r_pwl_x <= w_sel_x;
    end
  end

  // The last tag stage is aligned with the PWL output for the same operand.
  assign w_out_tag = r_tag[PWL_LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= '0;
      r_rsp_y     <= '0;
    end else if (w_out_tag.valid) begin
      r_rsp_y <= bus.pwl_y;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_rsp_valid[i] <= (w_out_tag.idx == TAG_IDX_W'(i));
      end
    end else begin
      r_rsp_valid <= '0;
    end
  end

  always_comb begin
    w_busy = |r_rsp_valid;
    for (int s = 0; s <= PWL_LAT; s++) w_busy = w_busy | r_tag[s].valid;
  end

  assign bus.req_ready = w_gnt;
  assign bus.pwl_x     = r_pwl_x;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_y     = r_rsp_y;
  assign busy          = w_busy;

`ifdef PWL_SHARE_SCHED_PERF_EN
  logic [15:0] r_gcnt [NUM_REQ];
  logic [31:0] r_bcnt;

  // Saturating counters; a clear in the same cycle as an increment wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bcnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_gcnt[i] <= '0;
    end else if (perf_clr) begin
      r_bcnt <= '0;
      for (int i = 0; i < NUM_REQ; i++) r_gcnt[i] <= '0;
    end else begin
      if (w_busy && (r_bcnt != 32'hFFFF_FFFF)) r_bcnt <= r_bcnt + 32'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_gnt[i] && (r_gcnt[i] != 16'hFFFF)) r_gcnt[i] <= r_gcnt[i] + 16'd1;
      end
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) grant_cnt[i*16 +: 16] = r_gcnt[i];
  end

  assign busy_cnt = r_bcnt;
`endif

endmodule

// File: tb/tb_pwl_share_sched.sv
// Self-checking bench for pwl_share_sched: table vectors, directed corner cases, random traffic.
module tb_pwl_share_sched;
  import pwl_pkg::*;

  localparam int NR  = 4;
  localparam int W   = 12;
  localparam int LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic perf_clr = 1'b0;
  logic busy, busy0;

  always #5 clk = ~clk;

  pwl_share_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus ();
  pwl_share_sched_if #(.NUM_REQ(NR), .WIDTH(W)) bus0 ();

`ifdef PWL_SHARE_SCHED_PERF_EN
  logic [NR*16-1:0] grant_cnt, grant_cnt0;
  logic [31:0]      busy_cnt, busy_cnt0;
`endif

  pwl_share_sched #(.NUM_REQ(NR), .WIDTH(W), .PWL_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus.slave),
`ifdef PWL_SHARE_SCHED_PERF_EN
    .perf_clr  (perf_clr),
    .grant_cnt (grant_cnt),
    .busy_cnt  (busy_cnt),
`endif
    .busy      (busy)
  );

  pwl_share_sched #(.NUM_REQ(NR), .WIDTH(W), .PWL_LAT(0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .bus       (bus0.slave),
`ifdef PWL_SHARE_SCHED_PERF_EN
    .perf_clr  (perf_clr),
    .grant_cnt (grant_cnt0),
    .busy_cnt  (busy_cnt0),
`endif
    .busy      (busy0)
  );

  // Identity PWL models: delayed by LAT for dut, combinational for dut0.
  logic [W-1:0] d1, d2;
  always @(posedge clk) begin
    d1 <= bus.pwl_x;
    d2 <= d1;
  end
  assign bus.pwl_y  = d2;
  assign bus0.pwl_y = bus0.pwl_x;

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    int           due;
    int           idx;
    logic [W-1:0] x;
  } op_t;

  op_t          exp_q[$];
  int           m_ptr;
  logic [W-1:0] m_pwl_x;
  logic [W-1:0] m_rsp_y;
  int           m_gcnt[NR];
  int           m_bcnt;
  int           cyc;
  int           n_cmp;
  int           n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic int exp_grant(input logic e, input logic [NR-1:0] v, input int p);
    if (!e) return -1;
    for (int k = 0; k < NR; k++) begin
      if (v[(p + k) % NR]) return (p + k) % NR;
    end
    return -1;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_ptr   = 0;
    m_pwl_x = '0;
    m_rsp_y = '0;
    m_bcnt  = 0;
    for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1; drives one cycle, checks at the falling edge, advances the model.
  task automatic run_cycle(input logic e, input logic [NR-1:0] v, input logic [NR*W-1:0] xs,
                           input logic clr, output logic [NR-1:0] rdy_s);
    int           g;
    logic [NR-1:0] exp_rv;
    logic [NR-1:0] exp_rdy;
    logic          exp_busy;
    en            = e;
    bus.req_valid = v;
    bus.req_x     = xs;
    perf_clr      = clr;
    #4;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
    exp_rv = '0;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      exp_rv[exp_q[0].idx] = 1'b1;
      m_rsp_y = exp_q[0].x;
    end
    exp_busy = (exp_q.size() > 0);
    g = exp_grant(e, v, m_ptr);
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    rdy_s = bus.req_ready;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("pwl_x", bus.pwl_x, m_pwl_x);
    chk("rsp_valid", bus.rsp_valid, exp_rv);
    chk("rsp_y", bus.rsp_y, m_rsp_y);
    chk("busy", busy, exp_busy);
    if (exp_busy) m_bcnt++;
    if (g >= 0) begin
      m_ptr   = (g + 1) % NR;
      m_pwl_x = xs[g*W +: W];
      exp_q.push_back('{due: cyc + LAT + 2, idx: g, x: xs[g*W +: W]});
      m_gcnt[g]++;
    end
    if (clr) begin
      m_bcnt = 0;
      for (int i = 0; i < NR; i++) m_gcnt[i] = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    logic [NR-1:0] r;
    for (int i = 0; i < n; i++) run_cycle(1'b1, '0, '0, 1'b0, r);
  endtask

  task automatic do_reset();
    en = 1'b0;
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_pwl_x", bus.pwl_x, '0);
    chk("rst_rsp_valid", bus.rsp_valid, '0);
    chk("rst_rsp_y", bus.rsp_y, '0);
    model_clear();
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          en;
    logic [NR-1:0] v;
    logic [NR-1:0] exp_rdy;
  } vec_t;

  vec_t tbl[20];

  initial begin
    logic [NR-1:0]   r;
    logic [NR*W-1:0] xs;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    bus.req_valid  = '0;
    bus.req_x      = '0;
    bus0.req_valid = '0;
    bus0.req_x     = '0;
    model_clear();

    repeat (2) @(posedge clk);
    #1;
    chk("init_busy", busy, 1'b0);
    chk("init_pwl_x", bus.pwl_x, '0);
    chk("init_rsp_valid", bus.rsp_valid, '0);
    chk("init_rsp_y", bus.rsp_y, '0);
    rst_n = 1'b1;
    en    = 1'b1;
    @(posedge clk);
    #1;
    cyc++;

    // PWL_LAT=0 instance: x=2047 from requester 2, response visible in cycle 2.
    bus0.req_valid = 4'b0100;
    bus0.req_x     = {12'd0, 12'h7FF, 12'd0, 12'd0};
    #4;
    chk("lat0_ready", bus0.req_ready, 4'b0100);
    chk("lat0_busy_c0", busy0, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
    bus0.req_valid = '0;
    #4;
    chk("lat0_pwl_x", bus0.pwl_x, 12'h7FF);
    chk("lat0_rsp_c1", bus0.rsp_valid, '0);
    chk("lat0_busy_c1", busy0, 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    #4;
    chk("lat0_rsp_c2", bus0.rsp_valid, 4'b0100);
    chk("lat0_rsp_y", bus0.rsp_y, 12'h7FF);
    chk("lat0_busy_c2", busy0, 1'b1);
    @(posedge clk);
    #1;
    cyc++;
    #4;
    chk("lat0_rsp_c3", bus0.rsp_valid, '0);
    chk("lat0_hold_y", bus0.rsp_y, 12'h7FF);
    chk("lat0_busy_c3", busy0, 1'b0);
`ifdef PWL_SHARE_SCHED_PERF_EN
    chk("lat0_grant_cnt2", grant_cnt0[2*16 +: 16], 16'd1);
    chk("lat0_busy_cnt", busy_cnt0, 32'd2);
`endif
    @(posedge clk);
    #1;
    cyc++;

    // Single request from requester 1 on the LAT=2 instance.
    do_reset();
    run_cycle(1'b1, 4'b0010, {12'd0, 12'd0, 12'd1024, 12'd0}, 1'b0, r);
    chk("single_ready", r, 4'b0010);
    idle(6);

    // Arbitration table starting from ptr=0.
    do_reset();
    tbl[0]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[1]  = '{1'b1, 4'b1111, 4'b0010};
    tbl[2]  = '{1'b1, 4'b1111, 4'b0100};
    tbl[3]  = '{1'b1, 4'b1111, 4'b1000};
    tbl[4]  = '{1'b1, 4'b1111, 4'b0001};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b1, 4'b1000, 4'b1000};
    tbl[7]  = '{1'b1, 4'b1001, 4'b0001};
    tbl[8]  = '{1'b1, 4'b1001, 4'b1000};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0000};
    tbl[10] = '{1'b0, 4'b1111, 4'b0000};
    tbl[11] = '{1'b0, 4'b1111, 4'b0000};
    tbl[12] = '{1'b0, 4'b1111, 4'b0000};
    tbl[13] = '{1'b0, 4'b1111, 4'b0000};
    tbl[14] = '{1'b0, 4'b1111, 4'b0000};
    tbl[15] = '{1'b1, 4'b0110, 4'b0010};
    tbl[16] = '{1'b1, 4'b0110, 4'b0100};
    tbl[17] = '{1'b1, 4'b0011, 4'b0001};
    tbl[18] = '{1'b1, 4'b0011, 4'b0010};
    tbl[19] = '{1'b1, 4'b0000, 4'b0000};
    xs = {12'd40, 12'd30, 12'd20, 12'd10};
    for (int i = 0; i < 20; i++) begin
      run_cycle(tbl[i].en, tbl[i].v, xs, 1'b0, r);
      chk($sformatf("tbl_ready[%0d]", i), r, tbl[i].exp_rdy);
    end
    idle(6);

    // Reset with two operations in flight: both are dropped.
    run_cycle(1'b1, 4'b1111, {12'd4, 12'd3, 12'd2, 12'd1}, 1'b0, r);
    run_cycle(1'b1, 4'b1111, {12'd4, 12'd3, 12'd2, 12'd1}, 1'b0, r);
    do_reset();
    idle(6);
    run_cycle(1'b1, 4'b1111, {12'd4, 12'd3, 12'd2, 12'd1}, 1'b0, r);
    chk("ptr_after_reset", r, 4'b0001);
    idle(6);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic          e;
      logic [NR-1:0] v;
      logic          c;
      e  = ($urandom_range(0, 7) != 0);
      v  = NR'($urandom);
      xs = {$urandom, $urandom};
      c  = ($urandom_range(0, 49) == 0);
      run_cycle(e, v, xs, c, r);
    end
    idle(6);

`ifdef PWL_SHARE_SCHED_PERF_EN
    for (int i = 0; i < NR; i++) begin
      chk($sformatf("grant_cnt[%0d]", i), grant_cnt[i*16 +: 16], m_gcnt[i]);
    end
    chk("busy_cnt", busy_cnt, m_bcnt);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
